// File: rtl/key_light_ctrl_pkg.sv
// Shared constants, types and object placement for the key/light controller.
package key_light_ctrl_pkg;

  // Top-level game state encodings that count as play stages.
  localparam logic [3:0] STAGE1 = 4'd2;
  localparam logic [3:0] STAGE2 = 4'd4;
  localparam logic [3:0] STAGE3 = 4'd6;

  // Side length of the key and switch squares, half-res pixels.
  localparam int unsigned OBJ_SIZE = 10;

  // Light switch square, only live in STAGE2.
  localparam logic [8:0] SWITCH_X = 9'd70;
  localparam logic [8:0] SWITCH_Y = 9'd220;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HUNT,
    ST_GRAB,
    ST_DONE
  } kl_state_e;

  typedef struct packed {
    logic [8:0] x;
    logic [8:0] y;
  } obj_pos_t;

  function automatic logic is_stage(input logic [3:0] s);
    return (s == STAGE1) || (s == STAGE2) || (s == STAGE3);
  endfunction

  // Top-left corner of key idx in the given stage. Index 3 (all keys held)
  // and non-stage states have no key; the origin is returned and the FSM
  // never acts on it in those cases.
  function automatic obj_pos_t key_pos(input logic [3:0] stage, input logic [1:0] idx);
    obj_pos_t p;
    p = '{x: 9'd0, y: 9'd0};
    case (stage)
      STAGE1: begin
        case (idx)
          2'd0:    p = '{x: 9'd70,  y: 9'd40};
          2'd1:    p = '{x: 9'd250, y: 9'd40};
          2'd2:    p = '{x: 9'd215, y: 9'd220};
          default: p = '{x: 9'd0,   y: 9'd0};
        endcase
      end
      STAGE2: begin
        case (idx)
          2'd0:    p = '{x: 9'd130, y: 9'd40};
          2'd1:    p = '{x: 9'd220, y: 9'd70};
          2'd2:    p = '{x: 9'd215, y: 9'd130};
          default: p = '{x: 9'd0,   y: 9'd0};
        endcase
      end
      STAGE3: begin
        case (idx)
          2'd0:    p = '{x: 9'd230, y: 9'd40};
          2'd1:    p = '{x: 9'd100, y: 9'd110};
          2'd2:    p = '{x: 9'd160, y: 9'd160};
          default: p = '{x: 9'd0,   y: 9'd0};
        endcase
      end
      default: p = '{x: 9'd0, y: 9'd0};
    endcase
    return p;
  endfunction

endpackage

// File: rtl/key_light_ctrl_if.sv
// Player/renderer-facing signal bundle of the key/light controller.
interface key_light_ctrl_if;

  logic [3:0] state;       // top-level game state
  logic       frame_tick;  // one-cycle pulse per frame
  logic [8:0] player_x;    // player hitbox top-left x
  logic [8:0] player_y;    // player hitbox top-left y
  logic       light_btn;   // debounced one-cycle press
  logic [1:0] key_find;    // next key to collect, 3 = all held
  logic       isDark;      // STAGE2 light-off flag
  logic       key_pulse;   // one cycle per collected key
  logic       all_keys;    // level while every key is held

  // Game side: drives player/frame inputs, observes key/light status.
  modport master (
    output state, frame_tick, player_x, player_y, light_btn,
    input  key_find, isDark, key_pulse, all_keys
  );

  // Controller side.
  modport slave (
    input  state, frame_tick, player_x, player_y, light_btn,
    output key_find, isDark, key_pulse, all_keys
  );

endinterface

// File: rtl/key_light_ctrl_rect_overlap.sv
// Combinational axis-aligned hitbox test: player rectangle vs object square.
module key_light_ctrl_rect_overlap #(
  parameter int unsigned PLAYER_W = 16,
  parameter int unsigned PLAYER_H = 16,
  parameter int unsigned OBJ_SIZE = 10
) (
  input  logic [8:0] px_i,
  input  logic [8:0] py_i,
  input  logic [8:0] ox_i,
  input  logic [8:0] oy_i,
  output logic       hit_o
);

  // One extra bit keeps coordinate + size sums from wrapping (max 319+16).
  logic [9:0] px, py, ox, oy;

  assign px = {1'b0, px_i};
  assign py = {1'b0, py_i};
  assign ox = {1'b0, ox_i};
  assign oy = {1'b0, oy_i};

  // Strict inequalities: rectangles that merely touch on an edge do not hit.
  assign hit_o = (px < ox + 10'(OBJ_SIZE)) &&
                 (px + 10'(PLAYER_W) > ox) &&
                 (py < oy + 10'(OBJ_SIZE)) &&
                 (py + 10'(PLAYER_H) > oy);

endmodule

// File: rtl/key_light_ctrl.sv
// Key collection sequencer and STAGE2 light switch.
module key_light_ctrl
  import key_light_ctrl_pkg::*;
#(
  parameter int unsigned PLAYER_W       = 16,
  parameter int unsigned PLAYER_H       = 16,
  parameter int unsigned LIGHT_COOLDOWN = 30
) (
  input  logic             clk,
  input  logic             rst,
  key_light_ctrl_if.slave  bus
);

  localparam int unsigned  CD_W    = $clog2(LIGHT_COOLDOWN + 1);
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(LIGHT_COOLDOWN);

  kl_state_e       fsm_q, fsm_d;
  logic [3:0]      stage_q;            // registered copy of bus.state
  logic [1:0]      key_find_q, key_find_d;
  logic            is_dark_q, is_dark_d;
  logic [CD_W-1:0] cooldown_q, cooldown_d;
  logic            pending_q, pending_d;

  logic            stage_change;
  logic            key_hit;
  logic            switch_hit;
  logic            key_allowed;
  logic            switch_live;
  logic            btn_seen;
  obj_pos_t        key_xy;

  assign stage_change = (bus.state != stage_q);
  assign key_xy       = key_pos(stage_q, key_find_q);

  // The first STAGE2 key only shows with the lights on; the check uses the
  // registered flag so a toggle on the same frame cannot unlock it early.
  assign key_allowed  = !((stage_q == STAGE2) && (key_find_q == 2'd0) && is_dark_q);
  assign switch_live  = (stage_q == STAGE2) && (fsm_q != ST_IDLE);
  assign btn_seen     = pending_q | bus.light_btn;

  key_light_ctrl_rect_overlap #(
    .PLAYER_W (PLAYER_W),
    .PLAYER_H (PLAYER_H),
    .OBJ_SIZE (OBJ_SIZE)
  ) u_key_hit (
    .px_i  (bus.player_x),
    .py_i  (bus.player_y),
    .ox_i  (key_xy.x),
    .oy_i  (key_xy.y),
    .hit_o (key_hit)
  );

  key_light_ctrl_rect_overlap #(
    .PLAYER_W (PLAYER_W),
    .PLAYER_H (PLAYER_H),
    .OBJ_SIZE (OBJ_SIZE)
  ) u_switch_hit (
    .px_i  (bus.player_x),
    .py_i  (bus.player_y),
    .ox_i  (SWITCH_X),
    .oy_i  (SWITCH_Y),
    .hit_o (switch_hit)
  );

  // Next-state logic for the FSM, key counter, light flag and cooldown.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    fsm_d      = fsm_q;
    key_find_d = key_find_q;
    is_dark_d  = is_dark_q;
    cooldown_d = cooldown_q;
    pending_d  = btn_seen;

    // Light switch: presses are remembered until the next frame evaluates.
    if (bus.frame_tick) begin
      pending_d = 1'b0;
      if (cooldown_q != '0) begin
        cooldown_d = cooldown_q - CD_W'(1);
      end
      if (switch_live && btn_seen && switch_hit && (cooldown_q == '0)) begin
        is_dark_d  = ~is_dark_q;
        cooldown_d = CD_LOAD;
      end
    end

    case (fsm_q)
      ST_IDLE: begin
        if (is_stage(stage_q)) begin
          fsm_d = ST_HUNT;
        end
      end
      ST_HUNT: begin
        // Counter advances on entry to GRAB so the pulse and the new index
        // appear together one cycle after the frame.
        if (bus.frame_tick && key_hit && key_allowed) begin
          fsm_d      = ST_GRAB;
          key_find_d = key_find_q + 2'd1;
        end
      end
      ST_GRAB: begin
        fsm_d = (key_find_q == 2'd3) ? ST_DONE : ST_HUNT;
      end
      ST_DONE: begin
        fsm_d = ST_DONE;
      end
      default: begin
        fsm_d = ST_IDLE;
      end
    endcase

    // A stage change wins over every other event in the same cycle.
    if (stage_change) begin
      fsm_d      = is_stage(bus.state) ? ST_HUNT : ST_IDLE;
      key_find_d = 2'd0;
      is_dark_d  = 1'b0;
      cooldown_d = '0;
      pending_d  = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      fsm_q      <= ST_IDLE;
      stage_q    <= 4'd0;
      key_find_q <= 2'd0;
      is_dark_q  <= 1'b0;
      cooldown_q <= '0;
      pending_q  <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      stage_q    <= bus.state;
      key_find_q <= key_find_d;
      is_dark_q  <= is_dark_d;
      cooldown_q <= cooldown_d;
      pending_q  <= pending_d;
    end
  end

  assign bus.key_find  = key_find_q;
  assign bus.isDark    = is_dark_q;
  assign bus.key_pulse = (fsm_q == ST_GRAB);
  assign bus.all_keys  = (fsm_q == ST_DONE);

endmodule
